// File: rtl/riscv_hazard_scoreboard.sv
// riscv_hazard_scoreboard
// Tracks in-flight destination registers through a shift register of
// PIPE_DEPTH stages and stalls the decode candidate on RAW hazards.
// Kills the youngest entries on a taken branch, reports writeback
// retirement, and counts stall cycles in a saturating counter.
// Optional build macro: RISCV_HAZARD_BYPASS_EN. When it is defined, the
// writeback stage writes through to the register file, so a match in that
// stage alone does not stall.
module riscv_hazard_scoreboard #(
  parameter int unsigned REG_WIDTH   = 5,
  parameter int unsigned PIPE_DEPTH  = 4,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned CNT_WIDTH   = 16,
  localparam int unsigned NUM_REGS   = 1 << REG_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REG_WIDTH-1:0] issue_rs1,
  input  logic [REG_WIDTH-1:0] issue_rs2,
  input  logic                 issue_rs1e,
  input  logic                 issue_rs2e,
  input  logic [REG_WIDTH-1:0] issue_rd,
  input  logic                 issue_rde,
  input  logic                 flush,
  input  logic                 cnt_clear,
  output logic                 stall,
  output logic                 issue_fire,
  output logic                 wb_valid,
  output logic [REG_WIDTH-1:0] wb_rd,
  output logic [NUM_REGS-1:0]  pending,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

`ifdef RISCV_HAZARD_BYPASS_EN
  localparam int unsigned HAZ_STAGES = PIPE_DEPTH - 1;
`else
  localparam int unsigned HAZ_STAGES = PIPE_DEPTH;
`endif

  logic [PIPE_DEPTH-1:0] stg_v;
  logic [REG_WIDTH-1:0]  stg_rd [PIPE_DEPTH];
  logic                  rs1_match;
  logic                  rs2_match;
  logic                  hazard;

  // Compare both sources against every stage that can still cause a hazard
  always_comb begin
    rs1_match = 1'b0;
    rs2_match = 1'b0;
    for (int unsigned k = 0; k < HAZ_STAGES; k++) begin
      if (stg_v[k] && (stg_rd[k] == issue_rs1)) rs1_match = 1'b1;
      if (stg_v[k] && (stg_rd[k] == issue_rs2)) rs2_match = 1'b1;
    end
    hazard     = (issue_rs1e && (issue_rs1 != '0) && rs1_match) ||
                 (issue_rs2e && (issue_rs2 != '0) && rs2_match);
    stall      = issue_valid && !flush && hazard;
    issue_fire = issue_valid && !flush && !hazard;
  end

  // Advance the tracking pipeline; flush invalidates entries landing in the
  // youngest FLUSH_DEPTH stages (stage 0 gets a bubble since nothing fires)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_v <= '0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) stg_rd[k] <= '0;
    end else begin
      stg_v[0]  <= issue_fire && issue_rde && (issue_rd != '0);
      stg_rd[0] <= issue_rd;
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
        stg_v[k]  <= stg_v[k-1] && !(flush && (k < FLUSH_DEPTH));
        stg_rd[k] <= stg_rd[k-1];
      end
    end
  end

  // Per-register pending mask and overall occupancy
  always_comb begin
    pending = '0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      if (stg_v[k]) pending[stg_rd[k]] = 1'b1;
    end
    busy = |stg_v;
  end

  assign wb_valid = stg_v[PIPE_DEPTH-1];
  assign wb_rd    = stg_rd[PIPE_DEPTH-1];

  // Saturating stall-cycle counter; clear takes priority over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (cnt_clear) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Directed testbench for riscv_hazard_scoreboard (PIPE_DEPTH=4,
// FLUSH_DEPTH=2, CNT_WIDTH=4). Expected stall lengths follow the
// RISCV_HAZARD_BYPASS_EN build setting.
module tb_riscv_hazard_scoreboard;

  localparam int CW = 4;
`ifdef RISCV_HAZARD_BYPASS_EN
  localparam int NS = 3;
  localparam int EXP_CNT10 = 7;
`else
  localparam int NS = 4;
  localparam int EXP_CNT10 = 8;
`endif

  logic          clk;
  logic          reset;
  logic          issue_valid;
  logic [4:0]    issue_rs1, issue_rs2, issue_rd;
  logic          issue_rs1e, issue_rs2e, issue_rde;
  logic          flush, cnt_clear;
  logic          stall, issue_fire, wb_valid, busy;
  logic [4:0]    wb_rd;
  logic [31:0]   pending;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  riscv_hazard_scoreboard #(
    .REG_WIDTH(5), .PIPE_DEPTH(4), .FLUSH_DEPTH(2), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1e(issue_rs1e), .issue_rs2e(issue_rs2e),
    .issue_rd(issue_rd), .issue_rde(issue_rde),
    .flush(flush), .cnt_clear(cnt_clear),
    .stall(stall), .issue_fire(issue_fire),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .pending(pending),
    .busy(busy), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    issue_rs1e = 0; issue_rs2e = 0; issue_rde = 0;
    flush = 0; cnt_clear = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (pending !== 32'h0) begin errors++; $display("FAIL rst_pending got=%h exp=0", pending); end
      checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", stall_cycles); end
      checks++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0) begin errors++; $display("FAIL rst_wb got=%b/%0d exp=0/0", wb_valid, wb_rd); end
    end
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_stall_busy got=%b%b exp=00", stall, busy); end
      checks++; if (pending !== 32'h0 || stall_cycles !== 4'd0) begin errors++; $display("FAIL idle_pend_cnt got=%h/%0d exp=0/0", pending, stall_cycles); end
    end
  endtask

  task automatic test_raw();
    logic done, es, ef;
    issue_valid = 1; issue_rd = 5; issue_rde = 1;
    #1;
    checks++; if (issue_fire !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL raw_first_fire got=%b/%b exp=1/0", issue_fire, stall); end
    tick();
    issue_rs1 = 5; issue_rs1e = 1; issue_rde = 0; issue_rd = 0;
    done = 0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      es = !done && (c <= NS);
      ef = !done && !es;
      checks++; if (stall !== es) begin errors++; $display("FAIL raw_stall c=%0d got=%b exp=%b", c, stall, es); end
      checks++; if (issue_fire !== ef) begin errors++; $display("FAIL raw_fire c=%0d got=%b exp=%b", c, issue_fire, ef); end
      checks++; if (wb_valid !== (c == 4)) begin errors++; $display("FAIL raw_wb_valid c=%0d got=%b exp=%b", c, wb_valid, c == 4); end
      if (c == 4) begin
        checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL raw_wb_rd got=%0d exp=5", wb_rd); end
      end
      checks++; if (pending[5] !== (c <= 4)) begin errors++; $display("FAIL raw_pending5 c=%0d got=%b exp=%b", c, pending[5], c <= 4); end
      tick();
      if (ef) begin done = 1; issue_valid = 0; end
    end
    checks++; if (stall_cycles !== 4'(NS)) begin errors++; $display("FAIL raw_cnt got=%0d exp=%0d", stall_cycles, NS); end
    idle_inputs();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL raw_drain got=%b exp=0", busy); end
  endtask

  task automatic test_x0();
    issue_valid = 1; issue_rd = 0; issue_rde = 1;
    #1;
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL x0_write_fire got=%b exp=1", issue_fire); end
    tick();
    checks++; if (busy !== 1'b0 || pending !== 32'h0) begin errors++; $display("FAIL x0_untracked got=%b/%h exp=0/0", busy, pending); end
    issue_rde = 0; issue_rs1 = 0; issue_rs1e = 1; issue_rs2 = 0; issue_rs2e = 1;
    #1;
    checks++; if (stall !== 1'b0 || issue_fire !== 1'b1) begin errors++; $display("FAIL x0_read got=%b/%b exp=0/1", stall, issue_fire); end
    tick();
    idle_inputs();
  endtask

  task automatic test_duplicate();
    logic done, es, ef;
    issue_valid = 1; issue_rd = 7; issue_rde = 1;
    tick();
    #1;
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL dup_second_fire got=%b exp=1", issue_fire); end
    tick();
    issue_rd = 0; issue_rde = 0; issue_rs2 = 7; issue_rs2e = 1;
    done = 0;
    for (int c = 2; c <= 7; c++) begin
      #1;
      es = !done && (c <= 1 + NS);
      ef = !done && !es;
      checks++; if (stall !== es || issue_fire !== ef) begin errors++; $display("FAIL dup_stall c=%0d got=%b/%b exp=%b/%b", c, stall, issue_fire, es, ef); end
      checks++; if (wb_valid !== (c == 4 || c == 5)) begin errors++; $display("FAIL dup_wb c=%0d got=%b exp=%b", c, wb_valid, c == 4 || c == 5); end
      checks++; if (pending[7] !== (c <= 5)) begin errors++; $display("FAIL dup_pending7 c=%0d got=%b exp=%b", c, pending[7], c <= 5); end
      tick();
      if (ef) begin done = 1; issue_valid = 0; end
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    logic [4:0] erd;
    for (int i = 1; i <= 3; i++) begin
      issue_valid = 1; issue_rd = 5'(i); issue_rde = 1;
      tick();
    end
    issue_rd = 4; issue_rs1 = 1; issue_rs1e = 1; flush = 1;
    #1;
    checks++; if (stall !== 1'b0 || issue_fire !== 1'b0) begin errors++; $display("FAIL flush_candidate got=%b/%b exp=0/0", stall, issue_fire); end
    checks++; if (pending !== 32'h0000_000E) begin errors++; $display("FAIL flush_pending_before got=%h exp=0000000e", pending); end
    tick();
    idle_inputs();
    for (int c = 4; c <= 7; c++) begin
      #1;
      erd = (c == 4) ? 5'd1 : 5'd2;
      checks++; if (wb_valid !== (c == 4 || c == 5)) begin errors++; $display("FAIL flush_wb c=%0d got=%b exp=%b", c, wb_valid, c == 4 || c == 5); end
      if (c == 4 || c == 5) begin
        checks++; if (wb_rd !== erd) begin errors++; $display("FAIL flush_wb_rd c=%0d got=%0d exp=%0d", c, wb_rd, erd); end
      end
      if (c == 4) begin
        checks++; if (pending !== 32'h0000_0006) begin errors++; $display("FAIL flush_pending_after got=%h exp=00000006", pending); end
      end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_drain got=%b exp=0", busy); end
  endtask

  task automatic test_counter();
    logic es;
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL cnt_clear_idle got=%0d exp=0", stall_cycles); end
    issue_valid = 1; issue_rs1 = 8; issue_rs1e = 1; issue_rd = 8; issue_rde = 1;
    for (int c = 0; c <= 30; c++) begin
      #1;
      es = (c % (NS + 1)) != 0;
      checks++; if (stall !== es) begin errors++; $display("FAIL cnt_stall c=%0d got=%b exp=%b", c, stall, es); end
      if (c == 10) begin
        checks++; if (stall_cycles !== 4'(EXP_CNT10)) begin errors++; $display("FAIL cnt_partial got=%0d exp=%0d", stall_cycles, EXP_CNT10); end
      end
      tick();
    end
    checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL cnt_saturate got=%0d exp=15", stall_cycles); end
    cnt_clear = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cnt_clear_during_stall got=%b exp=1", stall); end
    tick();
    cnt_clear = 0; issue_valid = 0;
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL cnt_cleared got=%0d exp=0", stall_cycles); end
    idle_inputs();
    repeat (5) tick();
    checks++; if (busy !== 1'b0 || stall_cycles !== 4'd0) begin errors++; $display("FAIL cnt_drain got=%b/%0d exp=0/0", busy, stall_cycles); end
  endtask

  task automatic test_mid_reset();
    issue_valid = 1; issue_rd = 6; issue_rde = 1;
    tick();
    idle_inputs();
    #1;
    checks++; if (busy !== 1'b1 || pending[6] !== 1'b1) begin errors++; $display("FAIL midrst_tracked got=%b/%b exp=1/1", busy, pending[6]); end
    reset = 0;
    #1;
    checks++; if (busy !== 1'b0 || pending !== 32'h0 || wb_valid !== 1'b0) begin errors++; $display("FAIL midrst_async got=%b/%h/%b exp=0/0/0", busy, pending, wb_valid); end
    tick();
    tick();
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_wb i=%0d got=%b exp=0", i, wb_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_x0();
    test_duplicate();
    test_flush();
    test_counter();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
